// File: rtl/uart_cmd_bus_master_if.sv
// Byte-stream and bus-master signal bundle for uart_cmd_bus_master.
// master: the bridge side; slave: the UART cores and bus fabric side.
interface uart_cmd_bus_master_if;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        m_valid;
  logic        m_write;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_ready;
  logic [31:0] m_rdata;
  logic        m_rvalid;

  modport master (
    input  rx_valid, rx_data, tx_ready, m_ready, m_rdata, m_rvalid,
    output rx_ready, tx_valid, tx_data, m_valid, m_write, m_addr, m_wdata, m_wstrb
  );

  modport slave (
    output rx_valid, rx_data, tx_ready, m_ready, m_rdata, m_rvalid,
    input  rx_ready, tx_valid, tx_data, m_valid, m_write, m_addr, m_wdata, m_wstrb
  );
endinterface

// File: rtl/uart_cmd_bus_master.sv
// UART command frames -> single bus master transactions, with byte responses.
// Define SNN_BRIDGE_CHKSUM_EN to require a trailing XOR checksum byte on every frame.
module uart_cmd_bus_master #(
  parameter int unsigned BUS_TIMEOUT = 256,
  parameter int unsigned CNT_W       = 9
) (
  input  logic                         clk,
  input  logic                         rst_n,
  uart_cmd_bus_master_if.master        bus,
  output logic                         busy,
  output logic [7:0]                   err_cnt
);

  localparam logic [7:0] CmdWrite = 8'hA5;
  localparam logic [7:0] CmdRead  = 8'h5A;
  localparam logic [7:0] RspAck   = 8'hAC;
  localparam logic [7:0] RspTmo   = 8'hEE;

  typedef enum logic [2:0] {StIdle, StAddr, StData, StChk, StBus, StResp} state_e;

  state_e           state_q, state_d;
  logic [1:0]       byte_cnt_q, byte_cnt_d;
  logic             write_q, write_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [3:0]       wstrb_q, wstrb_d;
  logic             m_valid_q, m_valid_d;
  logic [CNT_W-1:0] tmo_q, tmo_d;
  logic             tx_valid_q, tx_valid_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic [23:0]      resp_q, resp_d;
  logic [1:0]       resp_left_q, resp_left_d;
  logic [7:0]       err_q, err_d;
`ifdef SNN_BRIDGE_CHKSUM_EN
  logic [7:0]       chk_q, chk_d;
`endif

  logic rx_ready, rx_fire, tx_fire, frame_done, start_bus, err_inc;

  assign rx_ready = (state_q == StIdle) || (state_q == StAddr) ||
                    (state_q == StData) || (state_q == StChk);
  assign rx_fire  = bus.rx_valid && rx_ready;
  assign tx_fire  = tx_valid_q && bus.tx_ready;

  always_comb begin
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    write_d     = write_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    m_valid_d   = m_valid_q;
    tmo_d       = tmo_q;
    tx_valid_d  = tx_valid_q;
    tx_data_d   = tx_data_q;
    resp_d      = resp_q;
    resp_left_d = resp_left_q;
    err_d       = err_q;
`ifdef SNN_BRIDGE_CHKSUM_EN
    chk_d       = chk_q;
`endif
    frame_done  = 1'b0;
    start_bus   = 1'b0;
    err_inc     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (rx_fire && (bus.rx_data == CmdWrite || bus.rx_data == CmdRead)) begin
          write_d    = (bus.rx_data == CmdWrite);
          byte_cnt_d = 2'd0;
          state_d    = StAddr;
`ifdef SNN_BRIDGE_CHKSUM_EN
          chk_d      = bus.rx_data;
`endif
        end
      end
      StAddr: begin
        if (rx_fire) begin
          addr_d     = {bus.rx_data, addr_q[31:8]};
          byte_cnt_d = byte_cnt_q + 2'd1;
`ifdef SNN_BRIDGE_CHKSUM_EN
          chk_d      = chk_q ^ bus.rx_data;
`endif
          if (byte_cnt_q == 2'd3) begin
            if (write_q) state_d = StData;
            else         frame_done = 1'b1;
          end
        end
      end
      StData: begin
        if (rx_fire) begin
          wdata_d    = {bus.rx_data, wdata_q[31:8]};
          byte_cnt_d = byte_cnt_q + 2'd1;
`ifdef SNN_BRIDGE_CHKSUM_EN
          chk_d      = chk_q ^ bus.rx_data;
`endif
          if (byte_cnt_q == 2'd3) frame_done = 1'b1;
        end
      end
`ifdef SNN_BRIDGE_CHKSUM_EN
      StChk: begin
        if (rx_fire) begin
          if (bus.rx_data == chk_q) begin
            start_bus = 1'b1;
          end else begin
            state_d     = StResp;
            tx_valid_d  = 1'b1;
            tx_data_d   = 8'hCE;
            resp_left_d = 2'd0;
            err_inc     = 1'b1;
          end
        end
      end
`endif
      StBus: begin
        tmo_d = tmo_q + CNT_W'(1);
        // Completion is tested before timeout so it wins on a shared edge.
        if (write_q && bus.m_ready) begin
          m_valid_d   = 1'b0;
          state_d     = StResp;
          tx_valid_d  = 1'b1;
          tx_data_d   = RspAck;
          resp_left_d = 2'd0;
        end else if (!write_q && bus.m_rvalid) begin
          m_valid_d   = 1'b0;
          state_d     = StResp;
          tx_valid_d  = 1'b1;
          tx_data_d   = bus.m_rdata[7:0];
          resp_d      = bus.m_rdata[31:8];
          resp_left_d = 2'd3;
        end else if (tmo_q == CNT_W'(BUS_TIMEOUT - 1)) begin
          m_valid_d   = 1'b0;
          state_d     = StResp;
          tx_valid_d  = 1'b1;
          tx_data_d   = RspTmo;
          resp_left_d = 2'd0;
          err_inc     = 1'b1;
        end
      end
      StResp: begin
        if (tx_fire) begin
          if (resp_left_q == 2'd0) begin
            tx_valid_d = 1'b0;
            state_d    = StIdle;
          end else begin
            tx_data_d   = resp_q[7:0];
            resp_d      = {8'h00, resp_q[23:8]};
            resp_left_d = resp_left_q - 2'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (frame_done) begin
`ifdef SNN_BRIDGE_CHKSUM_EN
      state_d = StChk;
`else
      start_bus = 1'b1;
`endif
    end

    if (start_bus) begin
      state_d   = StBus;
      m_valid_d = 1'b1;
      tmo_d     = '0;
      wstrb_d   = write_q ? 4'hF : 4'h0;
    end

    if (err_inc && err_q != 8'hFF) err_d = err_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      byte_cnt_q  <= '0;
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      m_valid_q   <= 1'b0;
      tmo_q       <= '0;
      tx_valid_q  <= 1'b0;
      tx_data_q   <= '0;
      resp_q      <= '0;
      resp_left_q <= '0;
      err_q       <= '0;
`ifdef SNN_BRIDGE_CHKSUM_EN
      chk_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      m_valid_q   <= m_valid_d;
      tmo_q       <= tmo_d;
      tx_valid_q  <= tx_valid_d;
      tx_data_q   <= tx_data_d;
      resp_q      <= resp_d;
      resp_left_q <= resp_left_d;
      err_q       <= err_d;
`ifdef SNN_BRIDGE_CHKSUM_EN
      chk_q       <= chk_d;
`endif
    end
  end

  assign bus.rx_ready = rx_ready;
  assign bus.tx_valid = tx_valid_q;
  assign bus.tx_data  = tx_data_q;
  assign bus.m_valid  = m_valid_q;
  assign bus.m_write  = write_q;
  assign bus.m_addr   = addr_q;
  assign bus.m_wdata  = wdata_q;
  assign bus.m_wstrb  = wstrb_q;
  assign busy         = (state_q != StIdle);
  assign err_cnt      = err_q;

endmodule

// File: tb/tb_uart_cmd_bus_master.sv
// Directed bench for uart_cmd_bus_master: vector table plus timeout, reset and
// checksum sequences.
module tb_uart_cmd_bus_master;

  localparam int unsigned Timeout = 256;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       busy;
  logic [7:0] err_cnt;

  uart_cmd_bus_master_if bus_if ();

  uart_cmd_bus_master dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus_if.master),
    .busy    (busy),
    .err_cnt (err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          wr;
    bit          junk;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          dly;
    int          stall;
    int          nresp;
    logic [31:0] resp;   // expected tx bytes, first byte in [7:0]
  } vec_t;

  vec_t       vecs [4];
  int         n_checks = 0;
  int         n_err = 0;
  logic [7:0] exp_err = 8'h00;
`ifdef SNN_BRIDGE_CHKSUM_EN
  logic [7:0] chk_flip = 8'h00;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int w;
    @(negedge clk);
    bus_if.rx_valid = 1'b1;
    bus_if.rx_data  = b;
    w = 0;
    while (!bus_if.rx_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (!bus_if.rx_ready) check("rx_ready_wait", {31'b0, bus_if.rx_ready}, 32'd1);
    @(posedge clk);
    #1;
    bus_if.rx_valid = 1'b0;
  endtask

  task automatic send_frame(input bit wr, input logic [31:0] addr, input logic [31:0] wdata);
    logic [7:0] x;
    x = wr ? 8'hA5 : 8'h5A;
    send_byte(x);
    for (int i = 0; i < 4; i++) begin
      send_byte(addr[8*i +: 8]);
      x = x ^ addr[8*i +: 8];
    end
    if (wr) begin
      for (int i = 0; i < 4; i++) begin
        send_byte(wdata[8*i +: 8]);
        x = x ^ wdata[8*i +: 8];
      end
    end
`ifdef SNN_BRIDGE_CHKSUM_EN
    send_byte(x ^ chk_flip);
`endif
  endtask

  // Called #1 after the edge that accepted the last frame byte.
  task automatic serve(input vec_t v);
    int hold_bad;
    check("m_valid_rise", {31'b0, bus_if.m_valid}, 32'd1);
    check("m_write", {31'b0, bus_if.m_write}, {31'b0, v.wr});
    check("m_addr", bus_if.m_addr, v.addr);
    if (v.wr) check("m_wdata", bus_if.m_wdata, v.wdata);
    check("m_wstrb", {28'b0, bus_if.m_wstrb}, v.wr ? 32'hF : 32'h0);
    check("rx_ready_bus", {31'b0, bus_if.rx_ready}, 32'd0);
    hold_bad = 0;
    repeat (v.dly) begin
      @(negedge clk);
      if (!bus_if.m_valid || bus_if.m_addr !== v.addr || bus_if.m_write !== v.wr) hold_bad++;
    end
    check("bus_hold", hold_bad, 0);
    @(negedge clk);
    if (v.wr) begin
      bus_if.m_ready = 1'b1;
    end else begin
      bus_if.m_rvalid = 1'b1;
      bus_if.m_rdata  = v.rdata;
    end
    @(posedge clk);
    #1;
    bus_if.m_ready  = 1'b0;
    bus_if.m_rvalid = 1'b0;
    bus_if.m_rdata  = 32'h0;
    check("m_valid_drop", {31'b0, bus_if.m_valid}, 32'd0);
    check("resp_latency", {31'b0, bus_if.tx_valid}, 32'd1);
  endtask

  task automatic recv_byte(input logic [7:0] exp, input int stall, input string name);
    int w;
    int moved;
    @(negedge clk);
    w = 0;
    while (!bus_if.tx_valid && w < 100) begin
      @(negedge clk);
      w++;
    end
    check({name, "_valid"}, {31'b0, bus_if.tx_valid}, 32'd1);
    check(name, {24'b0, bus_if.tx_data}, {24'b0, exp});
    check({name, "_rx_blocked"}, {31'b0, bus_if.rx_ready}, 32'd0);
    if (stall > 0) begin
      moved = 0;
      repeat (stall) begin
        @(negedge clk);
        if (!bus_if.tx_valid || bus_if.tx_data !== exp) moved++;
      end
      check({name, "_stall_stable"}, moved, 0);
    end
    bus_if.tx_ready = 1'b1;
    @(posedge clk);
    #1;
    bus_if.tx_ready = 1'b0;
  endtask

  task automatic finish_resp(input string name);
    check({name, "_tx_drop"}, {31'b0, bus_if.tx_valid}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    check({name, "_idle"}, {31'b0, busy}, 32'd0);
    check({name, "_err_cnt"}, {24'b0, err_cnt}, {24'b0, exp_err});
  endtask

  task automatic run_vec(input vec_t v, input string name);
    if (v.junk) begin
      send_byte(8'h00);
      send_byte(8'hFF);
      @(negedge clk);
      check("junk_busy", {31'b0, busy}, 32'd0);
      check("junk_m_valid", {31'b0, bus_if.m_valid}, 32'd0);
    end
    send_frame(v.wr, v.addr, v.wdata);
    serve(v);
    for (int i = 0; i < v.nresp; i++) recv_byte(v.resp[8*i +: 8], (i == 0) ? v.stall : 0, name);
    finish_resp(name);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    int cnt;
    vec_t r;

    vecs[0] = '{wr: 1'b1, junk: 1'b0, addr: 32'h4000_0004, wdata: 32'h0000_000A, rdata: 32'h0,
                dly: 2, stall: 0, nresp: 1, resp: 32'h0000_00AC};
    vecs[1] = '{wr: 1'b0, junk: 1'b0, addr: 32'h4000_0020, wdata: 32'h0, rdata: 32'h1234_5678,
                dly: 0, stall: 0, nresp: 4, resp: 32'h1234_5678};
    vecs[2] = '{wr: 1'b0, junk: 1'b1, addr: 32'h0000_0100, wdata: 32'h0, rdata: 32'hDEAD_BEEF,
                dly: 3, stall: 20, nresp: 4, resp: 32'hDEAD_BEEF};
    vecs[3] = '{wr: 1'b1, junk: 1'b0, addr: 32'hFFFF_FFFC, wdata: 32'h8000_0001, rdata: 32'h0,
                dly: 0, stall: 0, nresp: 1, resp: 32'h0000_00AC};

    bus_if.rx_valid = 1'b0;
    bus_if.rx_data  = 8'h00;
    bus_if.tx_ready = 1'b0;
    bus_if.m_ready  = 1'b0;
    bus_if.m_rdata  = 32'h0;
    bus_if.m_rvalid = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rx_ready", {31'b0, bus_if.rx_ready}, 32'd1);
    check("rst_tx_valid", {31'b0, bus_if.tx_valid}, 32'd0);
    check("rst_tx_data", {24'b0, bus_if.tx_data}, 32'd0);
    check("rst_m_valid", {31'b0, bus_if.m_valid}, 32'd0);
    check("rst_m_write", {31'b0, bus_if.m_write}, 32'd0);
    check("rst_m_addr", bus_if.m_addr, 32'd0);
    check("rst_m_wdata", bus_if.m_wdata, 32'd0);
    check("rst_m_wstrb", {28'b0, bus_if.m_wstrb}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_err_cnt", {24'b0, err_cnt}, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Write that is never acknowledged.
    send_frame(1'b1, 32'h4000_0008, 32'h0000_0055);
    check("tmo_m_valid_rise", {31'b0, bus_if.m_valid}, 32'd1);
    cnt = 0;
    while (bus_if.m_valid && cnt < 1000) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    check("tmo_cycles", cnt, Timeout);
    exp_err = exp_err + 8'd1;
    check("tmo_err_cnt", {24'b0, err_cnt}, {24'b0, exp_err});
    recv_byte(8'hEE, 0, "tmo_resp");
    finish_resp("tmo");

    // Reset in the middle of an address field, then a clean read.
    send_byte(8'h5A);
    send_byte(8'h20);
    send_byte(8'h00);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_err = 8'h00;
    check("midrst_busy", {31'b0, busy}, 32'd0);
    check("midrst_m_valid", {31'b0, bus_if.m_valid}, 32'd0);
    check("midrst_tx_valid", {31'b0, bus_if.tx_valid}, 32'd0);
    check("midrst_err_cnt", {24'b0, err_cnt}, 32'd0);
    r = '{wr: 1'b0, junk: 1'b0, addr: 32'h4000_0030, wdata: 32'h0, rdata: 32'hA1B2_C3D4,
          dly: 1, stall: 0, nresp: 4, resp: 32'hA1B2_C3D4};
    run_vec(r, "postrst");

`ifdef SNN_BRIDGE_CHKSUM_EN
    chk_flip = 8'h01;
    send_frame(1'b0, 32'h4000_0020, 32'h0);
    chk_flip = 8'h00;
    check("badchk_no_m_valid", {31'b0, bus_if.m_valid}, 32'd0);
    exp_err = exp_err + 8'd1;
    recv_byte(8'hCE, 0, "badchk_resp");
    finish_resp("badchk");
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
